// File: rtl/mem_stage.sv
// MEM stage of the five-stage MIPS pipeline: turns the EXE result into a data-bus
// access, stalls upstream until the access completes, and holds the result while downstream stalls.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_write_mem,
  input  logic        i_write_regfile,
  input  logic        i_mem_to_regfile,
  input  logic [31:0] i_da,
  input  logic [31:0] i_db,
  input  logic [4:0]  i_rn,
  input  logic [7:0]  i_mem_control,
  input  logic        i_stall,
  output logic        o_stall_req,
  output logic        o_write_regfile,
  output logic [4:0]  o_rn,
  output logic [31:0] o_wdata,
  output logic        o_adel,
  output logic        o_ades,
  output logic [31:0] o_badvaddr,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] rdata_r;
  logic        capture_s;
  logic        req_s;
  logic        stall_s;
  logic [1:0]  size_s;
  logic [1:0]  lane_s;
  logic        is_load_s;
  logic        misalign_s;
  logic        access_s;
  logic [3:0]  strb_s;
  logic [31:0] lanes_s;
  logic        unused_s;

  // Shift the addressed byte/half down to bit 0, then zero- or sign-extend it.
  function automatic logic [31:0] extract_load(input logic [31:0] rdata, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = rdata >> {lane, 3'b000};
    case (size)
      2'b00:   result = uns ? {24'h000000, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   result = uns ? {16'h0000, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: result = rdata;
    endcase
    return result;
  endfunction

  assign unused_s   = ^i_mem_control[7:3];
  assign size_s     = i_mem_control[1:0];
  assign lane_s     = i_da[1:0];
  // A store wins when both memory flags are set.
  assign is_load_s  = i_mem_to_regfile & ~i_write_mem;
  assign misalign_s = ((size_s == 2'b01) & i_da[0]) |
                      (size_s[1] & (i_da[1:0] != 2'b00));
  assign access_s   = (i_write_mem | i_mem_to_regfile) & ~misalign_s;

  // Byte-lane replication and strobes for stores.
  always_comb begin
    lanes_s = i_db;
    strb_s  = 4'b1111;
    case (size_s)
      2'b00: begin
        lanes_s = {4{i_db[7:0]}};
        strb_s  = 4'b0001 << lane_s;
      end
      2'b01: begin
        lanes_s = {2{i_db[15:0]}};
        strb_s  = 4'b0011 << lane_s;
      end
      default: begin
        lanes_s = i_db;
        strb_s  = 4'b1111;
      end
    endcase
  end

  // Next-state and handshake decode.
  always_comb begin
    next_state_s = state_r;
    req_s        = 1'b0;
    stall_s      = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (access_s) begin
          req_s   = 1'b1;
          stall_s = 1'b1;
          if (data_addr_ok) begin
            next_state_s = ST_WAIT;
          end else begin
            next_state_s = ST_REQ;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        req_s   = 1'b1;
        stall_s = 1'b1;
        if (data_addr_ok) begin
          next_state_s = ST_WAIT;
        end else begin
          next_state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        stall_s = 1'b1;
        if (data_data_ok) begin
          capture_s    = 1'b1;
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        // The upstream register advances on the same edge that releases DONE.
        if (i_stall) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register and captured read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      rdata_r <= 32'h0000_0000;
    end else begin
      state_r <= next_state_s;
      if (capture_s) begin
        rdata_r <= data_rdata;
      end
    end
  end

  assign data_req    = req_s & ~reset;
  assign data_wr     = i_write_mem;
  assign data_size   = (size_s == 2'b11) ? 2'b10 : size_s;
  assign data_addr   = i_da;
  assign data_wstrb  = i_write_mem ? strb_s : 4'b0000;
  assign data_wdata  = lanes_s;

  assign o_stall_req = stall_s;
  assign o_adel      = is_load_s & misalign_s;
  assign o_ades      = i_write_mem & misalign_s;
  assign o_badvaddr  = (o_adel | o_ades) ? i_da : 32'h0000_0000;
  assign o_rn        = i_rn;
  assign o_write_regfile = i_write_regfile & ~o_stall_req & ~o_adel & ~o_ades & ~i_write_mem;
  assign o_wdata     = ((state_r == ST_DONE) && is_load_s) ?
                       extract_load(rdata_r, lane_s, size_s, i_mem_control[2]) : i_da;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a table of single-cycle decode vectors, hand-written bus sequences,
// and randomized transactions checked against a byte-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_write_mem, i_write_regfile, i_mem_to_regfile, i_stall;
  logic [31:0] i_da, i_db;
  logic [4:0]  i_rn;
  logic [7:0]  i_mem_control;
  logic        o_stall_req, o_write_regfile, o_adel, o_ades;
  logic [4:0]  o_rn;
  logic [31:0] o_wdata, o_badvaddr;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .i_write_mem(i_write_mem), .i_write_regfile(i_write_regfile),
    .i_mem_to_regfile(i_mem_to_regfile), .i_da(i_da), .i_db(i_db), .i_rn(i_rn),
    .i_mem_control(i_mem_control), .i_stall(i_stall),
    .o_stall_req(o_stall_req), .o_write_regfile(o_write_regfile), .o_rn(o_rn),
    .o_wdata(o_wdata), .o_adel(o_adel), .o_ades(o_ades), .o_badvaddr(o_badvaddr),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_write_mem = 1'b0; i_write_regfile = 1'b0; i_mem_to_regfile = 1'b0;
    i_da = 32'h0; i_db = 32'h0; i_rn = 5'd0; i_mem_control = 8'h00; i_stall = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
  endtask

  // Reference: the addressed bytes read as an integer, extended by plain arithmetic.
  function automatic logic [31:0] model_load(input logic [31:0] rd, input int a, input int nb,
                                             input logic uns);
    longint v, span;
    if (nb == 4) return rd;
    span = longint'(1) << (8 * nb);
    v = (longint'(rd) >> (8 * a)) % span;
    if (!uns && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // One instruction through the stage with a bus that accepts after ad cycles and answers
  // after dd wait cycles; hold = cycles of downstream stall once the result is ready.
  task automatic run_txn(input string nm, input logic wm, input logic ml, input logic wrf,
                         input logic [1:0] sz, input logic uns, input logic [31:0] da,
                         input logic [31:0] db, input logic [31:0] rd,
                         input int ad, input int dd, input int hold);
    int nb, a, phase, k, stalls, reqs;
    logic mis, is_load, finished, seq_ok;
    logic [3:0]  e_strb;
    logic [31:0] e_bw, e_wd, held;
    logic [4:0]  rn;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    a = int'(da[1:0]);
    is_load = ml & ~wm;
    mis = (wm | ml) && ((da % nb) != 0);
    e_strb = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      e_bw[8*i +: 8] = db[8*(i % nb) +: 8];
      if (wm && i >= a && i < a + nb) e_strb[i] = 1'b1;
    end
    rn = 5'($urandom);
    i_write_mem = wm; i_mem_to_regfile = ml; i_write_regfile = wrf;
    i_da = da; i_db = db; i_rn = rn; i_stall = 1'b0;
    i_mem_control = {5'($urandom), uns, sz};
    if (!(wm | ml) || mis) begin
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      #2;
      check({nm, ".adel"}, o_adel, is_load & mis);
      check({nm, ".ades"}, o_ades, wm & mis);
      check({nm, ".badv"}, o_badvaddr, mis ? da : 32'h0);
      check({nm, ".nostall"}, {o_stall_req, data_req}, 2'b00);
      check({nm, ".wrf"}, o_write_regfile, wrf & ~wm & ~mis);
      check({nm, ".wdata"}, o_wdata, da);
      check({nm, ".rn"}, o_rn, rn);
      @(posedge clk); #1;
      clear_inputs();
      return;
    end
    phase = 0; k = 0; stalls = 0; reqs = 0; finished = 1'b0; seq_ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      data_addr_ok = (phase == 0) && (k == ad);
      data_data_ok = (phase == 1) ? (k == dd) : ($urandom_range(0, 1) == 1);
      data_rdata   = (phase == 1 && k == dd) ? rd : ~rd;
      #2;
      if (c == 0) begin
        check({nm, ".wr"}, data_wr, wm);
        check({nm, ".size"}, data_size, (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2);
        check({nm, ".wstrb"}, data_wstrb, e_strb);
        if (wm) check({nm, ".bus_wdata"}, data_wdata, e_bw);
      end
      if (!o_stall_req) begin finished = 1'b1; break; end
      stalls++;
      if (phase == 0) begin
        reqs++;
        if (data_req !== 1'b1 || data_addr !== da) seq_ok = 1'b0;
        if (data_addr_ok) begin phase = 1; k = 0; end else k++;
      end else begin
        if (data_req !== 1'b0) seq_ok = 1'b0;
        if (phase == 1) begin
          if (k == dd) phase = 2; else k++;
        end
      end
    end
    e_wd = is_load ? model_load(rd, a, nb, uns) : da;
    check({nm, ".finished"}, finished, 1'b1);
    check({nm, ".stalls"}, stalls, 2 + ad + dd);
    check({nm, ".req_cycles"}, reqs, ad + 1);
    check({nm, ".bus_seq"}, seq_ok, 1'b1);
    check({nm, ".result"}, o_wdata, e_wd);
    check({nm, ".wrf_done"}, o_write_regfile, wrf & ~wm);
    check({nm, ".req_done"}, data_req, 1'b0);
    if (hold > 0) begin
      held = o_wdata;
      seq_ok = 1'b1;
      i_stall = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        data_data_ok = ($urandom_range(0, 1) == 1);
        data_rdata = $urandom;
        #2;
        if (o_wdata !== e_wd || o_wdata !== held || data_req !== 1'b0 || o_stall_req !== 1'b0)
          seq_ok = 1'b0;
      end
      check({nm, ".hold"}, seq_ok, 1'b1);
      i_stall = 1'b0;
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  typedef struct {
    logic wm; logic ml; logic wrf; logic [31:0] da; logic [31:0] db; logic [7:0] ctrl;
    logic e_stall; logic e_wrf; logic e_adel; logic e_ades; logic e_req; logic e_wr;
    logic [1:0] e_size; logic [3:0] e_wstrb; logic [31:0] e_wdata; logic [31:0] e_badv;
    logic [31:0] e_bwdata;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // wm ml wrf da db ctrl | stall wrf adel ades req wr size wstrb wdata badv bus_wdata
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h12345678, 32'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 32'h12345678, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h00001001, 32'h0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 4'b0000, 32'h00001001, 32'h00001001, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h00001002, 32'hAABBCCDD, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 4'b1111, 32'h00001002, 32'h00001002, 32'hAABBCCDD};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h00000101, 32'h00001234, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0110, 32'h00000101, 32'h00000101, 32'h12341234};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h00000102, 32'h0000BEEF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 4'b1100, 32'h00000102, 32'h0, 32'hBEEFBEEF};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h00000201, 32'h0000005A, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 4'b0010, 32'h00000201, 32'h0, 32'h5A5A5A5A};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h00000300, 32'h0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 4'b0000, 32'h00000300, 32'h0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h00000400, 32'hCAFEF00D, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 4'b1111, 32'h00000400, 32'h0, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h00000501, 32'h0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 4'b1111, 32'h00000501, 32'h00000501, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0000ABCD, 32'h0, 8'hF8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 32'h0000ABCD, 32'h0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h00000103, 32'h0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 32'h00000103, 32'h00000103, 32'h0};

    clear_inputs();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #2;
    check("rst.outs", {o_stall_req, o_write_regfile, o_adel, o_ades, data_req, data_wr}, 6'b0);
    check("rst.wdata", o_wdata, 32'h0);
    check("rst.badv", o_badvaddr, 32'h0);
    check("rst.bus", {data_size, data_wstrb, data_wdata[25:0]}, 32'h0);
    @(posedge clk); #1;

    for (int v = 0; v < 11; v++) begin
      i_write_mem = vecs[v].wm; i_mem_to_regfile = vecs[v].ml; i_write_regfile = vecs[v].wrf;
      i_da = vecs[v].da; i_db = vecs[v].db; i_mem_control = vecs[v].ctrl; i_rn = 5'(v);
      #2;
      check($sformatf("vec%0d.stall", v), o_stall_req, vecs[v].e_stall);
      check($sformatf("vec%0d.wrf", v), o_write_regfile, vecs[v].e_wrf);
      check($sformatf("vec%0d.adel", v), o_adel, vecs[v].e_adel);
      check($sformatf("vec%0d.ades", v), o_ades, vecs[v].e_ades);
      check($sformatf("vec%0d.req", v), data_req, vecs[v].e_req);
      check($sformatf("vec%0d.wr", v), data_wr, vecs[v].e_wr);
      check($sformatf("vec%0d.size", v), data_size, vecs[v].e_size);
      check($sformatf("vec%0d.wstrb", v), data_wstrb, vecs[v].e_wstrb);
      check($sformatf("vec%0d.wdata", v), o_wdata, vecs[v].e_wdata);
      check($sformatf("vec%0d.badv", v), o_badvaddr, vecs[v].e_badv);
      check($sformatf("vec%0d.bus_wdata", v), data_wdata, vecs[v].e_bwdata);
      check($sformatf("vec%0d.addr", v), data_addr, vecs[v].da);
      check($sformatf("vec%0d.rn", v), o_rn, 5'(v));
      clear_inputs();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end

    run_txn("lb_signed", 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h00000403, 32'h0, 32'h80FF1122, 0, 0, 0);
    run_txn("lbu", 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 32'h00000403, 32'h0, 32'h80FF1122, 0, 0, 0);
    run_txn("sh", 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h00000102, 32'h0000BEEF, 32'h0, 0, 0, 0);
    run_txn("lw_backpressure", 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h00002000, 32'h0, 32'hDEADBEEF, 3, 1, 0);
    run_txn("lh_hold", 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h00000842, 32'h0, 32'h9ABC1234, 1, 0, 3);

    // Reset while the request is outstanding.
    i_mem_to_regfile = 1'b1; i_write_regfile = 1'b1; i_da = 32'h00000600; i_mem_control = 8'h02;
    #2;
    check("rstreq.idle_req", data_req, 1'b1);
    @(posedge clk); #1;
    #2;
    check("rstreq.in_req", {data_req, o_stall_req}, 2'b11);
    reset = 1'b1;
    #1;
    check("rstreq.req_drop", data_req, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_inputs();
    i_write_regfile = 1'b1; i_da = 32'h00000077;
    #2;
    check("rstreq.after", {o_stall_req, data_req, o_write_regfile}, 3'b001);
    check("rstreq.wdata", o_wdata, 32'h00000077);
    @(posedge clk); #1;
    clear_inputs();

    for (int t = 0; t < 60; t++) begin
      int kind, sz, nb;
      logic [31:0] da;
      kind = $urandom_range(0, 3);
      sz = $urandom_range(0, 3);
      nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
      da = $urandom;
      if ($urandom_range(0, 3) != 0) da = da & ~32'(nb - 1);
      case (kind)
        0: run_txn($sformatf("rnd%0d", t), 1'b0, 1'b0, 1'($urandom), 2'(sz), 1'($urandom), da, $urandom, $urandom, 0, 0, 0);
        1: run_txn($sformatf("rnd%0d", t), 1'b0, 1'b1, 1'b1, 2'(sz), 1'($urandom), da, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        2: run_txn($sformatf("rnd%0d", t), 1'b1, 1'b0, 1'b0, 2'(sz), 1'($urandom), da, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        default: run_txn($sformatf("rnd%0d", t), 1'b1, 1'b1, 1'b1, 2'(sz), 1'($urandom), da, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), 0);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
